// File: rtl/snn_input_loader.sv
// snn_input_loader: unpacks a byte-wide image frame into single-bit input RAM writes,
// kicks snn_core, and sends the classified digit as ASCII. Optional: SNN_LOADER_TIMEOUT_EN.
module snn_input_loader #(
    parameter int NUM_BYTES = 98,
    parameter int ADDR_W    = 10,
    parameter int TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_data,
    output logic              snn_start,
    input  logic              snn_done,
    input  logic [3:0]        snn_digit,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              ovr,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_KICK, S_WAIT, S_SEND} state_t;

    state_t            state_q, state_d;
    logic [7:0]        hold_q, hold_d, shift_q, shift_d, res_q, res_d, tx_data_q, tx_data_d;
    logic              hold_v_q, hold_v_d;
    logic [6:0]        byte_q, byte_d;
    logic [2:0]        bit_q, bit_d;
    logic              ram_we_q, ram_we_d, ram_data_q, ram_data_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              snn_start_q, snn_start_d, tx_start_q, tx_start_d;
    logic              busy_q, busy_d, ovr_q, ovr_d;
    logic              consume, capture;
`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    // The holding slot frees up in the same cycle IDLE consumes it, so a byte
    // arriving right then is still captured.
    assign consume = (state_q == S_IDLE) && hold_v_q;
    assign capture = rx_rdy && (!hold_v_q || consume) && (state_q == S_IDLE || state_q == S_UNPACK);

    always_comb begin
        state_d     = state_q;
        hold_d      = capture ? rx_data : hold_q;
        hold_v_d    = capture ? 1'b1 : (consume ? 1'b0 : hold_v_q);
        ovr_d       = ovr_q || (rx_rdy && !capture);
        shift_d     = shift_q;
        byte_d      = byte_q;
        bit_d       = bit_q;
        res_d       = res_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        snn_start_d = 1'b0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
`ifdef SNN_LOADER_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: if (hold_v_q) begin
                ram_we_d   = 1'b1;
                ram_addr_d = ADDR_W'({byte_q, 3'd0});
                ram_data_d = hold_q[0];
                shift_d    = hold_q >> 1;
                bit_d      = 3'd1;
                state_d    = S_UNPACK;
            end
            // bit_q wraps to 0 once bit 7 has been issued; that cycle closes the byte.
            S_UNPACK: if (bit_q != 3'd0) begin
                ram_we_d   = 1'b1;
                ram_addr_d = ADDR_W'({byte_q, bit_q});
                ram_data_d = shift_q[0];
                shift_d    = shift_q >> 1;
                bit_d      = bit_q + 3'd1;
            end else if (byte_q == 7'(NUM_BYTES - 1)) begin
                byte_d      = 7'd0;
                snn_start_d = 1'b1;
                state_d     = S_KICK;
            end else begin
                byte_d  = byte_q + 7'd1;
                state_d = S_IDLE;
            end
            S_KICK: begin
`ifdef SNN_LOADER_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: if (snn_done) begin
                res_d   = {4'h3, snn_digit};
                state_d = S_SEND;
`ifdef SNN_LOADER_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                res_d   = 8'h3F;
                state_d = S_SEND;
            end else begin
                cnt_d = cnt_q + 1'b1;
`endif
            end
            S_SEND: if (!tx_busy) begin
                tx_start_d = 1'b1;
                tx_data_d  = res_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_v_q    <= 1'b0;
            shift_q     <= '0;
            byte_q      <= '0;
            bit_q       <= '0;
            res_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= 1'b0;
            snn_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_v_q    <= hold_v_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            bit_q       <= bit_d;
            res_q       <= res_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            snn_start_q <= snn_start_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
`ifdef SNN_LOADER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign snn_start = snn_start_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign ovr       = ovr_q;
`ifdef SNN_LOADER_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif
endmodule

// File: tb/tb_snn_input_loader.sv
// tb_snn_input_loader: directed self-checking bench for snn_input_loader.
module tb_snn_input_loader;
    logic       clk = 1'b0, rst = 1'b1, rx_rdy = 1'b0, snn_done = 1'b0, tx_busy = 1'b0;
    logic [7:0] rx_data = '0;
    logic [3:0] snn_digit = '0;
    logic       ram_we, ram_data, snn_start, tx_start, busy, ovr, err;
    logic [9:0] ram_addr;
    logic [7:0] tx_data;

    int tests = 0, fails = 0, cyc = 0;
    int wcnt = 0, starts = 0, txs = 0, gaps = 0;
    int first_w_cyc, last_w_cyc, start_cyc, tx_cyc, rx_cyc, rx0, t0;
    logic [9:0] first_addr, last_addr;
    logic [7:0] tx_val, got;
    logic       tx_busy_seen;
    logic       mem [0:1023];

    snn_input_loader #(.NUM_BYTES(98), .ADDR_W(10), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .snn_start(snn_start), .snn_done(snn_done), .snn_digit(snn_digit),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .ovr(ovr), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ram_we) begin
            if (wcnt == 0) begin
                first_w_cyc = cyc;
                first_addr  = ram_addr;
            end else if (ram_addr != 10'(last_addr + 10'd1)) gaps++;
            mem[ram_addr] = ram_data;
            last_addr  = ram_addr;
            last_w_cyc = cyc;
            wcnt++;
        end
        if (snn_start) begin
            starts++;
            start_cyc = cyc;
        end
        if (tx_start) begin
            txs++;
            tx_cyc       = cyc;
            tx_val       = tx_data;
            tx_busy_seen = busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i, input int mode);
        return mode == 0 ? 8'hA5 : 8'(i * 37 + 1);
    endfunction

    task automatic pulse(input logic [7:0] b);
        @(posedge clk);
        #1 rx_rdy = 1'b1;
        rx_data = b;
        rx_cyc = cyc;
        @(posedge clk);
        #1 rx_rdy = 1'b0;
    endtask

    task automatic frame(input int first, input int last, input int mode, input int gap);
        for (int i = first; i <= last; i++) begin
            pulse(pat(i, mode));
            if (i == first) rx0 = rx_cyc;
            repeat (gap) @(posedge clk);
        end
    endtask

    task automatic clear();
        wcnt = 0;
        starts = 0;
        txs = 0;
        gaps = 0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 100 && starts == 0; i++) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 50 && txs == 0; i++) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic grab(input int base);
        for (int b = 0; b < 8; b++) got[b] = mem[base + b];
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {ram_we, ram_addr, ram_data, snn_start, tx_start, tx_data, busy, ovr, err}, 0);
        rst = 1'b0;

        // full frame of A5, 16-cycle spacing
        clear();
        frame(0, 97, 0, 14);
        wait_start();
        chk("frame_writes", wcnt, 784);
        chk("first_write_latency", first_w_cyc - rx0, 2);
        chk("addr0", mem[0], 1);
        chk("addr1", mem[1], 0);
        chk("addr2", mem[2], 1);
        chk("addr783", mem[783], 1);
        chk("addr_gaps", gaps, 0);
        chk("start_count", starts, 1);
        chk("start_after_last_write", start_cyc - last_w_cyc, 1);
        chk("busy_wait", busy, 1);
        chk("ovr_clean", ovr, 0);

        // byte during WAIT is dropped
        pulse(8'hFF);
        repeat (2) @(negedge clk);
        chk("ovr_wait_drop", ovr, 1);
        chk("no_write_in_wait", wcnt, 784);

        // result path, transmitter idle
        @(posedge clk);
        #1 snn_done = 1'b1;
        snn_digit = 4'd7;
        t0 = cyc;
        @(posedge clk);
        #1 snn_done = 1'b0;
        wait_tx();
        chk("tx_count", txs, 1);
        chk("tx_latency", tx_cyc - t0, 2);
        chk("tx_data_7", tx_val, 8'h37);
        chk("busy_after_tx", tx_busy_seen, 0);

        // minimum 10-cycle spacing, varied bytes, transmitter busy, digit 12
        clear();
        frame(0, 97, 1, 8);
        wait_start();
        chk("frame2_writes", wcnt, 784);
        grab(400);
        chk("frame2_byte50", got, pat(50, 1));
        grab(776);
        chk("frame2_byte97", got, pat(97, 1));
        tx_busy = 1'b1;
        @(posedge clk);
        #1 snn_done = 1'b1;
        snn_digit = 4'd12;
        @(posedge clk);
        #1 snn_done = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("tx_held_busy", txs, 0);
        chk("busy_in_send", busy, 1);
        @(posedge clk);
        #1 tx_busy = 1'b0;
        t0 = cyc;
        wait_tx();
        chk("tx_after_release", tx_cyc - t0, 1);
        chk("tx_data_12", tx_val, 8'h3C);
        chk("ovr_sticky", ovr, 1);

        // asynchronous reset in the middle of byte 39
        clear();
        frame(0, 38, 0, 8);
        pulse(8'h81);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_before_rst", {ram_we, busy}, 2'b11);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset_outputs", {ram_we, ram_addr, ram_data, snn_start, tx_start, tx_data, busy, ovr, err}, 0);
        #1 rst = 1'b0;
        clear();
        for (int b = 0; b < 8; b++) mem[b] = 1'bx;
        pulse(8'h3C);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("post_rst_writes", wcnt, 8);
        chk("post_rst_first_addr", first_addr, 0);
        chk("post_rst_last_addr", last_addr, 7);
        grab(0);
        chk("post_rst_byte", got, 8'h3C);

        // back-to-back bytes, third one overruns
        clear();
        @(posedge clk);
        #1 rx_rdy = 1'b1;
        rx_data = 8'h5A;
        @(posedge clk);
        #1 rx_data = 8'hC3;
        @(posedge clk);
        #1 rx_data = 8'hFF;
        @(negedge clk);
        chk("b2b_ovr_clear", ovr, 0);
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        @(negedge clk);
        chk("b2b_ovr_set", ovr, 1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("b2b_writes", wcnt, 16);
        chk("b2b_first_addr", first_addr, 8);
        chk("b2b_last_addr", last_addr, 23);
        chk("b2b_gaps", gaps, 0);
        grab(8);
        chk("b2b_byte1", got, 8'h5A);
        grab(16);
        chk("b2b_byte2", got, 8'hC3);

        // finish the frame and never answer
        clear();
        frame(3, 97, 0, 8);
        wait_start();
        chk("frame3_start", starts, 1);
        repeat (150) @(posedge clk);
        @(negedge clk);
`ifdef SNN_LOADER_TIMEOUT_EN
        chk("timeout_err", err, 1);
        chk("timeout_tx", txs, 1);
        chk("timeout_char", tx_val, 8'h3F);
        chk("timeout_idle", busy, 0);
`else
        chk("no_timeout_busy", busy, 1);
        chk("no_timeout_err", err, 0);
        chk("no_timeout_tx", txs, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
